// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Master identifiers
  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  // Bus-cycle counter
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  // Counter preload for a transaction lasting 'cycles' bus cycles
  function automatic cnt_t cnt_load(input int cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the master that did not win last time wins a tie.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick2
  import bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid = req0 | req1;

  // Single requester wins outright; on a tie the previous owner yields
  always_comb begin
    winner = M_CPU;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = M_AUX;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter driving the bridge lines from registers for BUS_CYCLES cycles.
// Latency: grant edge -> BUS_CYCLES bus cycles -> one-cycle ack (BUS_CYCLES+2 per txn).
// Backpressure: masters hold req until ack; requests wait while a transaction is in flight.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int BUS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic [31:0] praddr,
  output logic [31:0] prwd,
  output logic        prwe,
  output logic [3:0]  prbe,
  input  logic [31:0] prrd
);

  localparam cnt_t CNT_LOAD = cnt_load(BUS_CYCLES);

  state_t state;
  logic   owner;
  logic   last;
  cnt_t   cnt;
  logic   pick_valid;
  logic   pick_winner;

  rr_pick2 u_pick (
    .req0   (m0_req),
    .req1   (m1_req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Arbitration FSM, bridge-line registers and read-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= M_CPU;
      last   <= M_AUX;
      cnt    <= '0;
      praddr <= '0;
      prwd   <= '0;
      prwe   <= 1'b0;
      prbe   <= '0;
      m0_rd  <= '0;
      m1_rd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_winner;
            cnt   <= CNT_LOAD;
            state <= BUS;
            if (pick_winner == M_AUX) begin
              praddr <= m1_addr;
              prwd   <= m1_wd;
              prwe   <= m1_we;
              prbe   <= m1_be;
            end else begin
              praddr <= m0_addr;
              prwd   <= m0_wd;
              prwe   <= m0_we;
              prbe   <= m0_be;
            end
          end
        end
        BUS: begin
          // Write strobe lasts only the first bus cycle so FIFO devices see one write
          prwe <= 1'b0;
          if (cnt == '0) begin
            if (owner == M_AUX) begin
              m1_rd <= prrd;
            end else begin
              m0_rd <= prrd;
            end
            last   <= owner;
            praddr <= '0;
            prwd   <= '0;
            prbe   <= '0;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // No arbitration here: a still-held req is taken as a new one from IDLE
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Acks come straight from state and owner, so they are mutually exclusive
  assign m0_ack = (state == DONE) && (owner == M_CPU);
  assign m1_ack = (state == DONE) && (owner == M_AUX);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: two instances (BUS_CYCLES = 1 and 3).
// Latency: n/a.
// Backpressure: n/a.
module tb_bus_arbiter;

  logic clk;
  logic reset;

  logic [1:0]       m0_req, m1_req, m0_we, m1_we;
  logic [1:0][31:0] m0_addr, m1_addr, m0_wd, m1_wd, prrd;
  logic [1:0][3:0]  m0_be, m1_be;
  logic [1:0]       m0_ack, m1_ack, prwe;
  logic [1:0][31:0] m0_rd, m1_rd, praddr, prwd;
  logic [1:0][3:0]  prbe;

  int n_tests;
  int n_fail;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_arbiter #(.BUS_CYCLES(g == 0 ? 1 : 3)) dut (
      .clk     (clk),
      .reset   (reset),
      .m0_req  (m0_req[g]),
      .m0_addr (m0_addr[g]),
      .m0_wd   (m0_wd[g]),
      .m0_we   (m0_we[g]),
      .m0_be   (m0_be[g]),
      .m0_ack  (m0_ack[g]),
      .m0_rd   (m0_rd[g]),
      .m1_req  (m1_req[g]),
      .m1_addr (m1_addr[g]),
      .m1_wd   (m1_wd[g]),
      .m1_we   (m1_we[g]),
      .m1_be   (m1_be[g]),
      .m1_ack  (m1_ack[g]),
      .m1_rd   (m1_rd[g]),
      .praddr  (praddr[g]),
      .prwd    (prwd[g]),
      .prwe    (prwe[g]),
      .prbe    (prbe[g]),
      .prrd    (prrd[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bc_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int k, input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
    if (m == 0) begin
      m0_req[k] = 1'b1; m0_we[k] = we; m0_addr[k] = addr; m0_wd[k] = wd; m0_be[k] = be;
    end else begin
      m1_req[k] = 1'b1; m1_we[k] = we; m1_addr[k] = addr; m1_wd[k] = wd; m1_be[k] = be;
    end
  endtask

  task automatic drop_req(input int k, input int m);
    if (m == 0) m0_req[k] = 1'b0;
    else        m1_req[k] = 1'b0;
  endtask

  task automatic clear_inputs();
    m0_req = '0; m1_req = '0; m0_we = '0; m1_we = '0;
    m0_addr = '0; m1_addr = '0; m0_wd = '0; m1_wd = '0;
    m0_be = '0; m1_be = '0; prrd = '0;
  endtask

  // Leaves the caller at a falling edge with reset released, DUTs in IDLE
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input int k, input string tag);
    chk({tag, " bus"}, {praddr[k], prwd[k], prbe[k], prwe[k]}, '0);
    chk({tag, " ack"}, {m0_ack[k], m1_ack[k]}, '0);
    chk({tag, " rd"},  {m0_rd[k], m1_rd[k]}, '0);
  endtask

  // Transaction-level reference: a grant at the end of cycle t occupies the bus in
  // cycles t+1..t+BC, acks in t+BC+1, and the next grant can happen at the end of t+BC+2.
  task automatic run_random(input int k, input int ncyc);
    int          bc;
    bit          active;
    int          s;
    logic        own, lst;
    logic        t_we;
    logic [31:0] t_addr, t_wd;
    logic [3:0]  t_be;
    logic [31:0] erd [2];
    bit          erd_ok [2];
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic        e_we;
    logic [1:0]  e_ack;
    logic        cur, ackm;
    bc = bc_of(k);
    clear_inputs();
    do_reset();
    active = 0; s = 0; own = 0; lst = 1;
    t_we = 0; t_addr = '0; t_wd = '0; t_be = '0;
    erd[0] = '0; erd[1] = '0; erd_ok[0] = 1; erd_ok[1] = 1;
    for (int t = 0; t < ncyc; t++) begin
      e_addr = '0; e_wd = '0; e_be = '0; e_we = 0; e_ack = 2'b00;
      if (active && t >= s && t <= s + bc - 1) begin
        e_addr = t_addr; e_wd = t_wd; e_be = t_be; e_we = t_we && (t == s);
      end
      if (active && t == s + bc) e_ack = own ? 2'b01 : 2'b10;
      chk($sformatf("rnd%0d c%0d bus", k, t), {praddr[k], prwd[k], prbe[k], prwe[k]},
          {e_addr, e_wd, e_be, e_we});
      chk($sformatf("rnd%0d c%0d ack", k, t), {m0_ack[k], m1_ack[k]}, e_ack);
      if (erd_ok[0]) chk($sformatf("rnd%0d c%0d m0_rd", k, t), m0_rd[k], erd[0]);
      if (erd_ok[1]) chk($sformatf("rnd%0d c%0d m1_rd", k, t), m1_rd[k], erd[1]);
      // Legal master behaviour: raise at will, only drop or retarget on ack
      for (int m = 0; m < 2; m++) begin
        cur  = (m == 0) ? m0_req[k] : m1_req[k];
        ackm = (m == 0) ? e_ack[1] : e_ack[0];
        if (!cur) begin
          if ($urandom_range(2) == 0)
            set_req(k, m, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom));
        end else if (ackm) begin
          if ($urandom_range(1) == 0) drop_req(k, m);
          else set_req(k, m, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom));
        end
      end
      prrd[k] = $urandom;
      if (active && t == s + bc - 1) begin
        erd[own] = prrd[k];
        erd_ok[own] = !t_we;
        lst = own;
      end
      if (!active || t >= s + bc + 1) begin
        if (m0_req[k] || m1_req[k]) begin
          own = (m0_req[k] && m1_req[k]) ? ~lst : m1_req[k];
          active = 1; s = t + 1;
          t_we   = own ? m1_we[k]   : m0_we[k];
          t_addr = own ? m1_addr[k] : m0_addr[k];
          t_wd   = own ? m1_wd[k]   : m0_wd[k];
          t_be   = own ? m1_be[k]   : m0_be[k];
        end else begin
          active = 0;
        end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  typedef struct {
    int          k;
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        exp_prwe;
    logic [31:0] exp_rd;
    bit          chk_other;
    logic [31:0] exp_other_rd;
  } vec_t;

  vec_t vt [6];

  initial begin
    int          n_ack, coinc, bc;
    int          who [4];
    int          when [4];
    bit          seen;
    vec_t        v;

    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    clear_inputs();

    vt[0] = '{0, 0, 1'b0, 32'h0000_7f00, 32'h1111_1111, 4'hf, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1, 32'h0};
    vt[1] = '{0, 1, 1'b0, 32'h0000_7f08, 32'h0,         4'hf, 32'ha5a5_a5a5, 1'b0, 32'ha5a5_a5a5, 1'b1, 32'h1234_5678};
    vt[2] = '{0, 0, 1'b0, 32'h0000_7f0c, 32'h0,         4'hf, 32'h0bad_f00d, 1'b0, 32'h0bad_f00d, 1'b1, 32'ha5a5_a5a5};
    vt[3] = '{1, 1, 1'b1, 32'h0000_7f10, 32'hdead_beef, 4'b0010, 32'hcafe_f00d, 1'b1, 32'h0, 1'b1, 32'h0};
    vt[4] = '{1, 0, 1'b0, 32'h0000_7f18, 32'h0,         4'b1100, 32'h55aa_00ff, 1'b0, 32'h55aa_00ff, 1'b0, 32'h0};
    vt[5] = '{0, 1, 1'b1, 32'h0000_7ffc, 32'hffff_ffff, 4'hf, 32'h7777_7777, 1'b1, 32'h0, 1'b1, 32'h0bad_f00d};

    // Reset state
    do_reset();
    chk_all_zero(0, "reset k0");
    chk_all_zero(1, "reset k1");

    // Single transactions from IDLE
    for (int i = 0; i < 6; i++) begin
      v  = vt[i];
      bc = bc_of(v.k);
      set_req(v.k, v.m, v.we, v.addr, v.wd, v.be);
      prrd[v.k] = v.rdata;
      @(negedge clk);
      for (int c = 0; c < bc; c++) begin
        chk($sformatf("v%0d b%0d praddr", i, c), praddr[v.k], v.addr);
        chk($sformatf("v%0d b%0d prwd/prbe", i, c), {prwd[v.k], prbe[v.k]}, {v.wd, v.be});
        chk($sformatf("v%0d b%0d prwe", i, c), prwe[v.k], (c == 0) ? v.exp_prwe : 1'b0);
        chk($sformatf("v%0d b%0d ack", i, c), {m0_ack[v.k], m1_ack[v.k]}, 2'b00);
        @(negedge clk);
      end
      chk($sformatf("v%0d done ack", i), {m0_ack[v.k], m1_ack[v.k]}, (v.m == 0) ? 2'b10 : 2'b01);
      chk($sformatf("v%0d done bus", i), {praddr[v.k], prwd[v.k], prbe[v.k], prwe[v.k]}, '0);
      if (!v.we)
        chk($sformatf("v%0d rd", i), (v.m == 0) ? m0_rd[v.k] : m1_rd[v.k], v.exp_rd);
      if (v.chk_other)
        chk($sformatf("v%0d other rd", i), (v.m == 0) ? m1_rd[v.k] : m0_rd[v.k], v.exp_other_rd);
      drop_req(v.k, v.m);
      @(negedge clk);
    end

    // Contention from reset, BUS_CYCLES=1
    clear_inputs();
    do_reset();
    for (int i = 0; i < 4; i++) begin who[i] = -1; when[i] = -100; end
    n_ack = 0; coinc = 0;
    set_req(0, 0, 1'b0, 32'h7f30, 32'h0, 4'hf);
    set_req(0, 1, 1'b0, 32'h7f34, 32'h0, 4'hf);
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(negedge clk);
      if (m0_ack[0] && m1_ack[0]) coinc++;
      if (m0_ack[0] || m1_ack[0]) begin
        who[n_ack] = m1_ack[0] ? 1 : 0;
        when[n_ack] = c;
        n_ack++;
      end
    end
    drop_req(0, 0);
    drop_req(0, 1);
    chk("cont ack count", n_ack, 4);
    chk("cont first ack cycle", when[0], 1);
    for (int i = 0; i < 4; i++) chk($sformatf("cont order %0d", i), who[i], i % 2);
    for (int i = 1; i < 4; i++) chk($sformatf("cont spacing %0d", i), when[i] - when[i-1], 3);
    chk("cont coincide", coinc, 0);
    @(negedge clk);

    // Back-to-back on one master with a retargeted address
    set_req(0, 0, 1'b0, 32'h7f00, 32'h0, 4'hf);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = m0_ack[0];
    end
    chk("b2b first ack seen", seen, 1'b1);
    set_req(0, 0, 1'b0, 32'h7f04, 32'h0, 4'hf);
    @(negedge clk);
    chk("b2b gap idle", {praddr[0], m0_ack[0], m1_ack[0]}, '0);
    @(negedge clk);
    chk("b2b second bus start", praddr[0], 32'h7f04);
    @(negedge clk);
    chk("b2b second ack", {m0_ack[0], m1_ack[0]}, 2'b10);
    drop_req(0, 0);
    @(negedge clk);

    // Reset in the first bus cycle of an m0 write (BUS_CYCLES=3)
    set_req(1, 0, 1'b1, 32'h7f20, 32'h1357_2468, 4'hf);
    @(negedge clk);
    chk("rstbus prwe before", prwe[1], 1'b1);
    #1 reset = 1'b1;
    #1 chk("rstbus prwe async", prwe[1], 1'b0);
    chk("rstbus no ack", {m0_ack[1], m1_ack[1]}, 2'b00);
    drop_req(1, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_all_zero(1, $sformatf("rstbus after %0d", c));
      @(negedge clk);
    end
    set_req(1, 0, 1'b0, 32'h7f40, 32'h0, 4'hf);
    set_req(1, 1, 1'b0, 32'h7f44, 32'h0, 4'hf);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = m0_ack[1] || m1_ack[1];
    end
    chk("rstbus tie winner", {m0_ack[1], m1_ack[1]}, 2'b10);
    drop_req(1, 0);
    drop_req(1, 1);
    @(negedge clk);

    // Randomised traffic against the transaction-level model
    run_random(0, 600);
    run_random(1, 600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
